// File: rtl/id_hazard_scoreboard.sv
// ID-stage register hazard scoreboard: per-GPR countdown of pipe advances until a result is forwardable.
// Optional HI/LO tracking is built when SB_HILO_EN is defined.
module id_hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int MAX_LAT = 7,
  localparam int AW = $clog2(NREG),
  localparam int LW = $clog2(MAX_LAT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs_addr,
  input  logic [AW-1:0]   id_rt_addr,
  input  logic            id_rs_rd,
  input  logic            id_rt_rd,
  input  logic [1:0]      id_hilo_rd,
  input  logic            id_issue,
  input  logic            id_wr_en,
  input  logic [AW-1:0]   id_wr_addr,
  input  logic [LW-1:0]   id_wr_lat,
  input  logic [1:0]      id_hilo_wr,
  input  logic [LW-1:0]   id_hilo_lat,
  input  logic            pipe_adv,
  input  logic            flush,
  output logic            stallreq,
  output logic [NREG-1:0] busy_vec,
  output logic [1:0]      hilo_busy
);

  logic [LW-1:0] cnt [1:NREG-1];
  logic          rs_busy, rt_busy;
  logic          iss;

  function automatic logic [LW-1:0] sat_lat(input logic [LW-1:0] lat);
    if (int'(lat) > MAX_LAT) return LW'(MAX_LAT);
    return lat;
  endfunction

  // Priority: flush, then a fresh load (never decremented in its own cycle), then countdown.
  function automatic logic [LW-1:0] next_cnt(input logic [LW-1:0] cur, input logic clr,
                                             input logic ld, input logic [LW-1:0] lat,
                                             input logic adv);
    if (clr)                  return '0;
    if (ld)                   return sat_lat(lat);
    if (adv && cur != '0)     return cur - 1'b1;
    return cur;
  endfunction

  always_comb begin
    busy_vec = '0;
    rs_busy  = 1'b0;
    rt_busy  = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      busy_vec[r] = (cnt[r] != '0);
      if (id_rs_addr == AW'(r)) rs_busy = busy_vec[r];
      if (id_rt_addr == AW'(r)) rt_busy = busy_vec[r];
    end
  end

  assign stallreq = id_valid & ((id_rs_rd & rs_busy) | (id_rt_rd & rt_busy) |
                                (id_hilo_rd[1] & hilo_busy[1]) | (id_hilo_rd[0] & hilo_busy[0]));
  assign iss = id_issue & id_valid & ~stallreq;

  // Register 0 has no counter, and addresses >= NREG match no counter, so neither ever loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 1; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++)
        cnt[r] <= next_cnt(cnt[r], flush, iss & id_wr_en & (id_wr_addr == AW'(r)),
                           id_wr_lat, pipe_adv);
    end
  end

`ifdef SB_HILO_EN
  logic [LW-1:0] cnt_hi, cnt_lo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_hi <= '0;
      cnt_lo <= '0;
    end else begin
      cnt_hi <= next_cnt(cnt_hi, flush, iss & id_hilo_wr[1], id_hilo_lat, pipe_adv);
      cnt_lo <= next_cnt(cnt_lo, flush, iss & id_hilo_wr[0], id_hilo_lat, pipe_adv);
    end
  end

  assign hilo_busy = {cnt_hi != '0, cnt_lo != '0};
`else
  logic unused_hilo;

  assign unused_hilo = ^{id_hilo_rd, id_hilo_wr, id_hilo_lat};
  assign hilo_busy   = 2'b00;
`endif

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed bench for id_hazard_scoreboard: a pending-advances model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_id_hazard_scoreboard;
  localparam int NREG    = 32;
  localparam int MAX_LAT = 7;
  localparam int AW      = $clog2(NREG);
  localparam int LW      = $clog2(MAX_LAT + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid, id_rs_rd, id_rt_rd, id_issue, id_wr_en, pipe_adv, flush;
  logic [AW-1:0]   id_rs_addr, id_rt_addr, id_wr_addr;
  logic [LW-1:0]   id_wr_lat, id_hilo_lat;
  logic [1:0]      id_hilo_rd, id_hilo_wr;
  logic            stallreq;
  logic [NREG-1:0] busy_vec;
  logic [1:0]      hilo_busy;

  int checks = 0;
  int errors = 0;

  // Model: number of pipe advances still owed before each register is forwardable.
  int owed [NREG];
  int owed_hi, owed_lo;

  id_hazard_scoreboard #(.NREG(NREG), .MAX_LAT(MAX_LAT)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_rd(id_rs_rd), .id_rt_rd(id_rt_rd), .id_hilo_rd(id_hilo_rd),
    .id_issue(id_issue), .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
    .id_wr_lat(id_wr_lat), .id_hilo_wr(id_hilo_wr), .id_hilo_lat(id_hilo_lat),
    .pipe_adv(pipe_adv), .flush(flush),
    .stallreq(stallreq), .busy_vec(busy_vec), .hilo_busy(hilo_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_hilo();
`ifdef SB_HILO_EN
    return {owed_hi > 0, owed_lo > 0};
`else
    return 2'b00;
`endif
  endfunction

  function automatic logic exp_stall();
    logic [1:0] hb;
    hb = exp_hilo();
    if (!id_valid) return 1'b0;
    return (id_rs_rd && owed[id_rs_addr] > 0) || (id_rt_rd && owed[id_rt_addr] > 0) ||
           (id_hilo_rd[1] && hb[1]) || (id_hilo_rd[0] && hb[0]);
  endfunction

  function automatic logic [NREG-1:0] exp_busy();
    logic [NREG-1:0] v;
    for (int r = 0; r < NREG; r++) v[r] = (owed[r] > 0);
    return v;
  endfunction

  function automatic int owe(input int lat);
    return (lat > MAX_LAT) ? MAX_LAT : lat;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) owed[r] = 0;
      owed_hi = 0;
      owed_lo = 0;
    end else begin
      automatic logic go = id_issue && id_valid && !exp_stall();
      for (int r = 0; r < NREG; r++) if (owed[r] > 0 && pipe_adv) owed[r]--;
      if (owed_hi > 0 && pipe_adv) owed_hi--;
      if (owed_lo > 0 && pipe_adv) owed_lo--;
      if (go && id_wr_en && id_wr_addr != 0) owed[id_wr_addr] = owe(int'(id_wr_lat));
      if (go && id_hilo_wr[1]) owed_hi = owe(int'(id_hilo_lat));
      if (go && id_hilo_wr[0]) owed_lo = owe(int'(id_hilo_lat));
      if (flush) begin
        for (int r = 0; r < NREG; r++) owed[r] = 0;
        owed_hi = 0;
        owed_lo = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("stallreq", 64'(stallreq), 64'(exp_stall()));
    check("busy_vec", 64'(busy_vec), 64'(exp_busy()));
    check("hilo_busy", 64'(hilo_busy), 64'(exp_hilo()));
  end

  task automatic idle();
    id_valid = 0; id_rs_rd = 0; id_rt_rd = 0; id_issue = 0; id_wr_en = 0;
    pipe_adv = 0; flush = 0; id_rs_addr = '0; id_rt_addr = '0; id_wr_addr = '0;
    id_wr_lat = '0; id_hilo_rd = '0; id_hilo_wr = '0; id_hilo_lat = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_wr(input int addr, input int lat, input logic adv);
    idle();
    id_valid = 1; id_issue = 1; id_wr_en = 1;
    id_wr_addr = AW'(addr); id_wr_lat = LW'(lat); pipe_adv = adv;
  endtask

  task automatic reader_rs(input int addr, input logic adv);
    idle();
    id_valid = 1; id_issue = 1; id_rs_rd = 1; id_rs_addr = AW'(addr); pipe_adv = adv;
  endtask

  initial begin
    idle();
    rst = 0;
    tick(); tick();
    check("reset_busy", 64'(busy_vec), 64'd0);
    check("reset_stall", 64'(stallreq), 64'd0);
    rst = 1;
    tick();

    // Load-use on r5, latency 1; load is not decremented in the issue cycle.
    issue_wr(5, 1, 1'b1); tick();
    reader_rs(5, 1'b0); #1;
    check("lu_stall0", 64'(stallreq), 64'd1);
    check("lu_busy5", 64'(busy_vec[5]), 64'd1);
    tick();
    pipe_adv = 1; #1;
    check("lu_stall1", 64'(stallreq), 64'd1);
    tick();
    check("lu_stall2", 64'(stallreq), 64'd0);
    check("lu_busy_clr", 64'(busy_vec), 64'd0);
    idle(); tick();

    // WAW: r7 L=5, one advance, then r7 L=1 overrides.
    issue_wr(7, 5, 1'b0); tick();
    idle(); pipe_adv = 1; tick();
    issue_wr(7, 1, 1'b1); tick();
    idle(); id_valid = 1; id_rt_rd = 1; id_rt_addr = AW'(7); #1;
    check("waw_stall_rt", 64'(stallreq), 64'd1);
    pipe_adv = 1; tick();
    check("waw_busy7", 64'(busy_vec[7]), 64'd0);
    idle(); tick();

    // Register 0 never becomes busy.
    issue_wr(0, 3, 1'b0); tick();
    reader_rs(0, 1'b0); #1;
    check("r0_busy", 64'(busy_vec), 64'd0);
    check("r0_stall", 64'(stallreq), 64'd0);
    idle(); tick();

    // Flush together with an issue to the same register: flush wins.
    issue_wr(3, 6, 1'b0); tick();
    issue_wr(3, 6, 1'b0); flush = 1; tick();
    check("flush_busy", 64'(busy_vec), 64'd0);
    issue_wr(3, 6, 1'b0); tick();
    idle(); pipe_adv = 1; tick(); tick();
    reader_rs(3, 1'b0); #1;
    check("pre_rst_stall", 64'(stallreq), 64'd1);
    #1 rst = 0; #1;
    check("async_rst_busy", 64'(busy_vec), 64'd0);
    check("async_rst_stall", 64'(stallreq), 64'd0);
    tick();
    rst = 1;
    idle(); tick();

    // Saturated latency input gives exactly MAX_LAT advances of busy.
    issue_wr(9, MAX_LAT, 1'b1); tick();
    idle(); pipe_adv = 1;
    for (int i = 0; i < MAX_LAT; i++) begin
      check("clamp_busy9", 64'(busy_vec[9]), 64'd1);
      tick();
    end
    check("clamp_clear9", 64'(busy_vec[9]), 64'd0);

    // Issue while stalled is ignored.
    issue_wr(4, 2, 1'b0); tick();
    issue_wr(6, 3, 1'b0); id_rs_rd = 1; id_rs_addr = AW'(4); #1;
    check("ign_stall", 64'(stallreq), 64'd1);
    tick();
    check("ign_busy6", 64'(busy_vec[6]), 64'd0);
    idle(); pipe_adv = 1; tick(); tick();
    check("ign_busy_clr", 64'(busy_vec), 64'd0);
    idle(); tick();

`ifdef SB_HILO_EN
    // HI/LO L=4 with three idle cycles interleaved: LO reader stalls seven cycles.
    begin
      int stalls = 0;
      idle(); id_valid = 1; id_issue = 1; id_hilo_wr = 2'b11; id_hilo_lat = LW'(4); tick();
      for (int i = 0; i < 9; i++) begin
        idle(); id_valid = 1; id_hilo_rd = 2'b01;
        pipe_adv = (i % 2 == 0); #1;
        if (stallreq) stalls++;
        tick();
      end
      check("hilo_stall_cycles", 64'(stalls), 64'd7);
      check("hilo_busy_clr", 64'(hilo_busy), 64'd0);
    end
`else
    idle(); id_valid = 1; id_issue = 1; id_hilo_wr = 2'b11; id_hilo_lat = LW'(4); tick();
    idle(); id_valid = 1; id_hilo_rd = 2'b11; #1;
    check("hilo_off_stall", 64'(stallreq), 64'd0);
    check("hilo_off_busy", 64'(hilo_busy), 64'd0);
    tick();
`endif

    idle(); tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
